// File: rtl/siso_ctrl_pkg.sv
// Shared types and sizing helpers for the SISO transfer controller.
// Optional parity readback is enabled with SISO_CTRL_PARITY_EN.
package siso_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  // Smallest w with 2**w > n.
  function automatic int min_cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) <= n) w = w + 1;
    return w;
  endfunction

  localparam int CNT_WIDTH_DEF =
    min_cnt_width(DATA_WIDTH_DEF);

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t RESP  = 2'd2;

endpackage

// File: rtl/siso_transfer_controller_bit_counter.sv
// Loadable down-counter with terminal-count flag.
// Used to time the SHIFT phase of the SISO controller.
module siso_ctrl_bit_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tc
);

  // Load wins over decrement; saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/siso_transfer_controller.sv
// Word-exchange engine for an external negedge SISO register.
// Define SISO_CTRL_PARITY_EN to add Rsp_Parity_Out.
module siso_transfer_controller
  import siso_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  Clk_In,
  input  logic                  Reset_N_In,
  input  logic                  Req_Valid_In,
  input  logic [DATA_WIDTH-1:0] Req_Data_In,
  output logic                  Req_Ready_Out,
  output logic                  Rsp_Valid_Out,
  output logic [DATA_WIDTH-1:0] Rsp_Data_Out,
  input  logic                  Rsp_Ready_In,
  output logic                  Siso_Enable_Out,
  output logic                  Siso_Shift_Out,
  output logic                  Siso_Data_Out,
  input  logic                  Siso_Data_In
`ifdef SISO_CTRL_PARITY_EN
  ,
  output logic                  Rsp_Parity_Out
`endif
);

  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] tx;
  logic [DATA_WIDTH-1:0] rx;
  logic [CNT_WIDTH-1:0]  count;
  logic                  tc;
  logic                  accept;
  logic                  in_shift;
`ifdef SISO_CTRL_PARITY_EN
  logic                  par;
`endif

  assign accept   = (state == IDLE) &&
                    Req_Ready_Out && Req_Valid_In;
  assign in_shift = (state == SHIFT);

  siso_ctrl_bit_counter #(
    .W(CNT_WIDTH)
  ) u_cnt (
    .clk      (Clk_In),
    .rst_n    (Reset_N_In),
    .load     (accept),
    .en       (in_shift),
    .load_val (LAST),
    .count    (count),
    .tc       (tc)
  );

  // FSM, serial tx/rx shifters and registered outputs.
  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state           <= IDLE;
      tx              <= '0;
      rx              <= '0;
      Req_Ready_Out   <= 1'b0;
      Rsp_Valid_Out   <= 1'b0;
      Rsp_Data_Out    <= '0;
      Siso_Enable_Out <= 1'b0;
      Siso_Shift_Out  <= 1'b0;
      Siso_Data_Out   <= 1'b0;
`ifdef SISO_CTRL_PARITY_EN
      par             <= 1'b0;
      Rsp_Parity_Out  <= 1'b0;
`endif
    end else begin
      Siso_Enable_Out <= 1'b1;
      unique case (state)
        IDLE: begin
          Req_Ready_Out <= 1'b1;
          if (accept) begin
            Req_Ready_Out  <= 1'b0;
            Siso_Shift_Out <= 1'b1;
            Siso_Data_Out  <= Req_Data_In[DATA_WIDTH-1];
            tx <= Req_Data_In << 1;
            rx <= {rx[DATA_WIDTH-2:0], Siso_Data_In};
`ifdef SISO_CTRL_PARITY_EN
            par <= Siso_Data_In;
`endif
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!tc) begin
            Siso_Data_Out <= tx[DATA_WIDTH-1];
            tx <= tx << 1;
            rx <= {rx[DATA_WIDTH-2:0], Siso_Data_In};
`ifdef SISO_CTRL_PARITY_EN
            par <= par ^ Siso_Data_In;
`endif
          end else begin
            Siso_Shift_Out <= 1'b0;
            Siso_Data_Out  <= 1'b0;
            Rsp_Data_Out   <= rx;
            Rsp_Valid_Out  <= 1'b1;
`ifdef SISO_CTRL_PARITY_EN
            Rsp_Parity_Out <= par;
`endif
            state <= RESP;
          end
        end
        RESP: begin
          if (Rsp_Ready_In) begin
            Rsp_Valid_Out <= 1'b0;
            Req_Ready_Out <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_siso_transfer_controller.sv
// Directed bench for siso_transfer_controller with a SISO model.
// Build with SISO_CTRL_PARITY_EN to also check Rsp_Parity_Out.
module tb_siso_transfer_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [15:0] req_data;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_ready;
  logic        s_en;
  logic        s_sh;
  logic        s_do;
  logic        s_di;
  logic        rsp_par;
  logic [15:0] siso = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  siso_transfer_controller dut (
    .Clk_In          (clk),
    .Reset_N_In      (rst_n),
    .Req_Valid_In    (req_valid),
    .Req_Data_In     (req_data),
    .Req_Ready_Out   (req_ready),
    .Rsp_Valid_Out   (rsp_valid),
    .Rsp_Data_Out    (rsp_data),
    .Rsp_Ready_In    (rsp_ready),
    .Siso_Enable_Out (s_en),
    .Siso_Shift_Out  (s_sh),
    .Siso_Data_Out   (s_do),
    .Siso_Data_In    (s_di)
`ifdef SISO_CTRL_PARITY_EN
    ,
    .Rsp_Parity_Out  (rsp_par)
`endif
  );

`ifndef SISO_CTRL_PARITY_EN
  assign rsp_par = 1'b0;
`endif

  // External SISO: negedge, MSB out, LSB in.
  always @(negedge clk)
    if (s_en && s_sh)
      siso <= {siso[14:0], s_do};

  assign s_di = siso[15];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic xfer(input logic [15:0] d,
                      input logic [15:0] exp,
                      input logic ep,
                      input int hold,
                      input string nm);
    logic [15:0] st;
    int ones;
    int t;
    bit ok;
    t = 0;
    while (!req_ready && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    chk({nm, " ready"}, req_ready, 1);
    if (!req_ready) return;
    req_valid = 1'b1;
    req_data  = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data  = '0;
    st   = '0;
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 15)
        chk({nm, " early rsp"}, rsp_valid, 0);
      ones += int'(s_sh);
      st = {st[14:0], s_do};
      @(posedge clk); #1;
    end
    chk({nm, " stream"}, st, d);
    chk({nm, " shifts"}, ones, 16);
    chk({nm, " idle line"}, {s_sh, s_do}, 0);
    chk({nm, " rsp valid"}, rsp_valid, 1);
    chk({nm, " rsp data"}, rsp_data, exp);
`ifdef SISO_CTRL_PARITY_EN
    chk({nm, " parity"}, rsp_par, ep);
`else
    if (ep === 1'bx) chk({nm, " ep"}, ep, 0);
`endif
    ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      req_valid = h[0];
      req_data  = 16'hDEAD;
      @(posedge clk); #1;
      if (!rsp_valid || rsp_data !== exp ||
          req_ready || s_sh)
        ok = 1'b0;
    end
    req_valid = 1'b0;
    if (hold > 0)
      chk({nm, " hold stable"}, ok, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({nm, " rsp clear"}, rsp_valid, 0);
    chk({nm, " back idle"}, req_ready, 1);
  endtask

  typedef struct {
    logic [15:0] d;
    logic [15:0] e;
    logic        p;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int last;
    int gap0;
    int gap1;
    int nrdy;
    int run;
    int maxrun;
    tbl[0] = '{16'hA5C3, 16'h0000, 1'b0};
    tbl[1] = '{16'h1234, 16'hA5C3, 1'b0};
    tbl[2] = '{16'h0F0F, 16'h1234, 1'b1};
    tbl[3] = '{16'h8001, 16'h0F0F, 1'b0};
    tbl[4] = '{16'h0007, 16'h8001, 1'b0};
    tbl[5] = '{16'h0003, 16'h0007, 1'b1};
    tbl[6] = '{16'h0000, 16'h0003, 1'b0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_data  = '0;
    rsp_ready = 1'b0;
    #1;
    chk("reset ctl",
        {req_ready, rsp_valid, s_en, s_sh, s_do, rsp_par}, 0);
    chk("reset data", rsp_data, 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("enable up", s_en, 1);
    chk("ready up", req_ready, 1);

    for (int i = 0; i < 7; i++)
      xfer(tbl[i].d, tbl[i].e, tbl[i].p, 0, "vec");

    xfer(16'hBEEF, 16'h0000, 1'b0, 10, "hold");

    // Reset mid-shift, between edges, in cycle 7.
    req_valid = 1'b1;
    req_data  = 16'h3C3C;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst ctl",
        {req_ready, rsp_valid, s_en, s_sh, s_do, rsp_par}, 0);
    chk("async rst data", rsp_data, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("partial siso", siso, 16'h779E);

    xfer(16'hFFFF, 16'h779E, 1'b1, 0, "post rst");
    xfer(16'h0000, 16'hFFFF, 1'b0, 0, "read ffff");

    // Back-to-back with the response side always ready.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_data  = 16'h5A5A;
    last = -1; gap0 = 0; gap1 = 0;
    nrdy = 0; run = 0; maxrun = 0;
    for (int c = 0; c < 60; c++) begin
      if (req_ready) begin
        run++;
        if (run > maxrun) maxrun = run;
        if (last >= 0 && nrdy == 1) gap0 = c - last;
        if (last >= 0 && nrdy == 2) gap1 = c - last;
        last = c;
        nrdy++;
      end else begin
        run = 0;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("b2b ready width", maxrun, 1);
    chk("b2b period 1", gap0, 18);
    chk("b2b period 2", gap1, 18);
    begin
      int t;
      t = 0;
      while (!req_ready && t < 40) begin
        @(posedge clk); #1;
        t++;
      end
    end
    rsp_ready = 1'b0;
    chk("b2b idle", req_ready, 1);
    chk("b2b siso", siso, 16'h5A5A);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
